// File: rtl/bus_pkg.sv
// bus_pkg -- shared types and default window map for the CPU bus controller.
//
// Contents:
//   bus_state_t  controller FSM states (IDLE, ACCESS, DONE, FAULT)
//   bus_tgt_t    slave target (TGT_RAM, TGT_MMIO)
//   bus_dec_t    address classifier result {hit, tgt, fault}
//   *_DEF        default window bases/sizes and watchdog length
//   win_hit()    window membership test for a naturally aligned window
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } bus_state_t;

  typedef enum logic {
    TGT_RAM  = 1'b0,
    TGT_MMIO = 1'b1
  } bus_tgt_t;

  typedef struct packed {
    logic     hit;
    bus_tgt_t tgt;
    logic     fault;
  } bus_dec_t;

  localparam logic [31:0] RAM_BASE_DEF   = 32'h0000_0000;
  localparam int          RAM_AW_DEF     = 16;
  localparam logic [31:0] MMIO_BASE_DEF  = 32'h1100_0000;
  localparam int          MMIO_AW_DEF    = 12;
  localparam int          TIMEOUT_DEF    = 16;

  // Windows are aligned to their own size, so membership is just a
  // comparison of the bits above the window offset.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int          aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/bus_decode.sv
// bus_decode -- combinational classifier for a CPU bus request.
//
// Ports:
//   rd, wr   in   CPU read / write request levels
//   addr     in   32-bit CPU byte address
//   dec      out  {hit, tgt, fault}: hit = address falls in a window,
//                 tgt = selected slave (RAM wins on overlap),
//                 fault = conflicting request, misaligned or unmapped
module bus_decode
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter int          RAM_AW    = RAM_AW_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          MMIO_AW   = MMIO_AW_DEF
) (
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  output bus_dec_t    dec
);

  logic ram_hit;
  logic mmio_hit;

  always_comb begin
    ram_hit   = win_hit(addr, RAM_BASE, RAM_AW);
    mmio_hit  = win_hit(addr, MMIO_BASE, MMIO_AW);
    dec.hit   = ram_hit | mmio_hit;
    // RAM is checked first so an overlapping map resolves to RAM.
    dec.tgt   = ram_hit ? TGT_RAM : TGT_MMIO;
    dec.fault = (rd & wr) | (addr[1:0] != 2'b00) | ~(ram_hit | mmio_hit);
  end

endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl -- single-word bus controller between the CPU bus and two
// slaves (RAM, MMIO) with a sel/ack handshake.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   busRead, busWrite        CPU request levels
//   bus_addr, bus_in         CPU byte address and write data
//   bus_out                  registered read data (0 after a fault)
//   bus_ready, error         one-cycle completion / fault strobes
//   ram_sel, mmio_sel        slave selects, held until ack or timeout
//   slv_we, slv_addr,
//   slv_wdata                latched request shared by both slaves
//   ram_rdata, ram_ack,
//   mmio_rdata, mmio_ack     slave responses
//
// Build option: define BUS_CTRL_TIMEOUT_EN to add a watchdog that faults
// an access whose slave has not acked within TIMEOUT_CYCLES select
// cycles. Without it, ACCESS waits for ack indefinitely.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE       = RAM_BASE_DEF,
  parameter int          RAM_AW         = RAM_AW_DEF,
  parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEF,
  parameter int          MMIO_AW        = MMIO_AW_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busRead,
  input  logic        busWrite,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_in,
  output logic [31:0] bus_out,
  output logic        bus_ready,
  output logic        error,
  output logic        ram_sel,
  output logic        mmio_sel,
  output logic        slv_we,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] mmio_rdata,
  input  logic        ram_ack,
  input  logic        mmio_ack
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("bus_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  bus_state_t  state_reg;
  bus_state_t  state_next;
  bus_tgt_t    tgt_reg;
  logic        slv_we_reg;
  logic [31:0] slv_addr_reg;
  logic [31:0] slv_wdata_reg;
  logic [31:0] bus_out_reg;

  logic        req;
  logic        tgt_ack;
  logic [31:0] tgt_rdata;
  bus_dec_t    dec;

  assign req = busRead | busWrite;

  bus_decode #(
    .RAM_BASE  (RAM_BASE),
    .RAM_AW    (RAM_AW),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_AW   (MMIO_AW)
  ) u_decode (
    .rd   (busRead),
    .wr   (busWrite),
    .addr (bus_addr),
    .dec  (dec)
  );

  // Only the latched target's handshake matters; the other slave's ack
  // and data are never looked at.
  assign tgt_ack   = (tgt_reg == TGT_RAM) ? ram_ack : mmio_ack;
  assign tgt_rdata = (tgt_reg == TGT_RAM) ? ram_rdata : mmio_rdata;

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            to_expired;

  // The count equals the number of select cycles already spent without
  // ack, so reaching TO_LAST means this is the last allowed cycle.
  assign to_expired = (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg <= '0;
    end else if (state_reg != ACCESS) begin
      to_cnt_reg <= '0;
    end else if (!tgt_ack && !to_expired) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  logic to_expired;
  assign to_expired = 1'b0;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (dec.fault || !dec.hit) begin
            state_next = FAULT;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack on the final allowed cycle still completes normally.
        if (tgt_ack) begin
          state_next = DONE;
        end else if (to_expired) begin
          state_next = FAULT;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs (decoded from registered state only) ----
  always_comb begin
    ram_sel   = (state_reg == ACCESS) && (tgt_reg == TGT_RAM);
    mmio_sel  = (state_reg == ACCESS) && (tgt_reg == TGT_MMIO);
    bus_ready = (state_reg == DONE) || (state_reg == FAULT);
    error     = (state_reg == FAULT);
  end

  // ---- request latches and read-data register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_reg       <= TGT_RAM;
      slv_we_reg    <= 1'b0;
      slv_addr_reg  <= '0;
      slv_wdata_reg <= '0;
      bus_out_reg   <= '0;
    end else begin
      // Every request is latched, faulting ones included.
      if (state_reg == IDLE && req) begin
        tgt_reg       <= dec.tgt;
        slv_we_reg    <= busWrite;
        slv_addr_reg  <= bus_addr;
        slv_wdata_reg <= bus_in;
      end
      // Cleared on entry to FAULT so bus_out reads 0 alongside the
      // error strobe; writes leave it untouched.
      if (state_next == FAULT) begin
        bus_out_reg <= '0;
      end else if (state_reg == ACCESS && tgt_ack && !slv_we_reg) begin
        bus_out_reg <= tgt_rdata;
      end
    end
  end

  assign slv_we    = slv_we_reg;
  assign slv_addr  = slv_addr_reg;
  assign slv_wdata = slv_wdata_reg;
  assign bus_out   = bus_out_reg;

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        busRead, busWrite;
  logic [31:0] bus_addr, bus_in;
  logic [31:0] bus_out;
  logic        bus_ready, error;
  logic        ram_sel, mmio_sel;
  logic        slv_we;
  logic [31:0] slv_addr, slv_wdata;
  logic [31:0] ram_rdata, mmio_rdata;
  logic        ram_ack, mmio_ack;

  int total  = 0;
  int passed = 0;
  logic [31:0] model_out = 32'h0;

  always #5 clk = ~clk;

  bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .busRead    (busRead),
    .busWrite   (busWrite),
    .bus_addr   (bus_addr),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_ready  (bus_ready),
    .error      (error),
    .ram_sel    (ram_sel),
    .mmio_sel   (mmio_sel),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .ram_rdata  (ram_rdata),
    .mmio_rdata (mmio_rdata),
    .ram_ack    (ram_ack),
    .mmio_ack   (mmio_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          d;      // ack presented in select cycle d+1
    logic [31:0] rdata;
    int          stray;  // cycle of a non-target ack pulse, 0 = none
    int          rdy;    // expected bus_ready cycle after request edge
    logic        err;
    logic [1:0]  sel;    // {mmio, ram}
    int          n;      // expected number of select cycles
    logic [31:0] out;
  } vec_t;

  // One transaction: request driven now, sampled at the next edge (cycle 0).
  // Called #1 after an edge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input string name);
    int k = 0, rdy_cyc = -1, sel_n = 0, bad = 0;
    logic err_v = 1'b0;
    logic [31:0] out_v = 32'h0;
    busRead  = v.rd;
    busWrite = v.wr;
    bus_addr = v.addr;
    bus_in   = v.wdata;
    while (k < 60 && rdy_cyc < 0) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        busRead  = 1'b0;
        busWrite = 1'b0;
        chk({name, " slv_addr"},  slv_addr,  v.addr);
        chk({name, " slv_we"},    {31'b0, slv_we}, {31'b0, v.wr});
        chk({name, " slv_wdata"}, slv_wdata, v.wdata);
      end
      if ({mmio_sel, ram_sel} != 2'b00) begin
        if ({mmio_sel, ram_sel} != v.sel) bad++;
        sel_n++;
      end
      if (error && !bus_ready) bad++;
      if (bus_ready) begin
        rdy_cyc = k;
        err_v   = error;
        out_v   = bus_out;
      end
      ram_ack    = 1'b0;
      mmio_ack   = 1'b0;
      ram_rdata  = $urandom;
      mmio_rdata = $urandom;
      if (rdy_cyc < 0) begin
        if (k == v.d + 1) begin
          if (v.sel == 2'b01) begin ram_ack = 1'b1; ram_rdata = v.rdata; end
          if (v.sel == 2'b10) begin mmio_ack = 1'b1; mmio_rdata = v.rdata; end
        end
        if (k == v.stray) begin
          if (v.sel == 2'b01) mmio_ack = 1'b1;
          if (v.sel == 2'b10) ram_ack = 1'b1;
        end
      end
    end
    ram_ack  = 1'b0;
    mmio_ack = 1'b0;
    chk({name, " ready_cycle"}, rdy_cyc, v.rdy);
    chk({name, " error"},       {31'b0, err_v}, {31'b0, v.err});
    chk({name, " bus_out"},     out_v, v.out);
    chk({name, " sel_cycles"},  sel_n, v.n);
    chk({name, " glitches"},    bad, 0);
    @(posedge clk); #1;
    chk({name, " strobe_drop"}, {30'b0, bus_ready, error}, 32'h0);
    model_out = v.out;
    $display("txn %-10s rd=%0b wr=%0b addr=%08h d=%0d -> ready@%0d err=%0b out=%08h",
             name, v.rd, v.wr, v.addr, v.d, rdy_cyc, err_v, out_v);
  endtask

  // Reference model: window membership by range arithmetic on the
  // default map, then latency from the ack delay and watchdog rules.
  task automatic model(inout vec_t v);
    logic in_ram, in_mmio, flt;
    bit to_en;
`ifdef BUS_CTRL_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    in_ram  = (v.addr < 32'h0001_0000);
    in_mmio = (v.addr >= 32'h1100_0000) && (v.addr < 32'h1100_1000);
    flt = (v.rd && v.wr) || (v.addr % 4 != 0) || !(in_ram || in_mmio);
    if (flt) begin
      v.rdy = 1; v.err = 1'b1; v.sel = 2'b00; v.n = 0; v.out = 32'h0;
    end else begin
      v.sel = in_ram ? 2'b01 : 2'b10;
      if (to_en && v.d >= TO) begin
        v.rdy = TO + 1; v.err = 1'b1; v.n = TO; v.out = 32'h0;
      end else begin
        v.rdy = v.d + 2; v.err = 1'b0; v.n = v.d + 1;
        v.out = v.rd ? v.rdata : model_out;
      end
    end
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    rst = 1'b1;
    busRead = 0; busWrite = 0; bus_addr = 0; bus_in = 0;
    ram_rdata = 0; mmio_rdata = 0; ram_ack = 0; mmio_ack = 0;

    //        rd   wr   addr           wdata         d  rdata          st rdy err sel    n  out
    tbl[0]  = '{1'b1,1'b0,32'h0000_0040,32'h0,        0, 32'hDEADBEEF, 0, 2, 1'b0,2'b01,1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0,1'b1,32'h1100_0004,32'h0000_00A5,2, 32'h0,        1, 4, 1'b0,2'b10,3, 32'hDEADBEEF};
    tbl[2]  = '{1'b1,1'b0,32'h2000_0000,32'h0,        0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};
    tbl[3]  = '{1'b1,1'b0,32'h0000_FFFC,32'h0,        1, 32'h1234_5678,0, 3, 1'b0,2'b01,2, 32'h1234_5678};
    tbl[4]  = '{1'b1,1'b0,32'h0000_0002,32'h0,        0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};
    tbl[5]  = '{1'b1,1'b0,32'h1100_0FFC,32'h0,        0, 32'hCAFE_F00D,0, 2, 1'b0,2'b10,1, 32'hCAFE_F00D};
    tbl[6]  = '{1'b1,1'b1,32'h0000_0040,32'h0000_0011,0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};
    tbl[7]  = '{1'b1,1'b0,32'h1100_0010,32'h0,        0, 32'h5555_AAAA,0, 2, 1'b0,2'b10,1, 32'h5555_AAAA};
    tbl[8]  = '{1'b1,1'b0,32'h0001_0000,32'h0,        0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};
    tbl[9]  = '{1'b1,1'b0,32'h1100_0020,32'h0,        0, 32'h0BAD_F00D,0, 2, 1'b0,2'b10,1, 32'h0BAD_F00D};
    tbl[10] = '{1'b0,1'b1,32'h1100_1000,32'h0000_0022,0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};
    tbl[11] = '{1'b0,1'b1,32'h0000_0100,32'h0000_0077,0, 32'h0,        0, 2, 1'b0,2'b01,1, 32'h0};
    tbl[12] = '{1'b0,1'b1,32'h1100_0001,32'h0000_0033,0, 32'h0,        0, 1, 1'b1,2'b00,0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {bus_out[0], bus_ready, error, ram_sel, mmio_sel, slv_we}, 32'h0);
    chk("reset bus_out", bus_out, 32'h0);
    chk("reset slv_addr", slv_addr, 32'h0);
    chk("reset slv_wdata", slv_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Stray mmio_ack while RAM is the target.
    v = '{1'b1,1'b0,32'h0000_0200,32'h0,3,32'hA1B2_C3D4,2,5,1'b0,2'b01,4,32'hA1B2_C3D4};
    run_txn(v, "stray");

`ifdef BUS_CTRL_TIMEOUT_EN
    v = '{1'b1,1'b0,32'h0000_0300,32'h0,1000,32'h0,0,TO+1,1'b1,2'b01,TO,32'h0};
    run_txn(v, "timeout");
    v = '{1'b1,1'b0,32'h0000_0304,32'h0,TO-1,32'h600D_0001,0,TO+1,1'b0,2'b01,TO,32'h600D_0001};
    run_txn(v, "ack_last");
`else
    v = '{1'b1,1'b0,32'h0000_0300,32'h0,40,32'h600D_0002,0,42,1'b0,2'b01,41,32'h600D_0002};
    run_txn(v, "long_wait");
`endif

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int r;
      v = '{default: '0};
      r = $urandom_range(0, 9);
      v.rd = (r == 0) || (r < 5);
      v.wr = (r == 0) || (r >= 5);
      case ($urandom_range(0, 4))
        0: v.addr = {16'h0, 16'($urandom) & 16'hFFFC};
        1: v.addr = 32'h1100_0000 | (32'($urandom_range(0, 1023)) << 2);
        2: v.addr = $urandom & 32'hFFFF_FFFC;
        3: v.addr = {16'h0, 16'($urandom)} | 32'h1;
        default: v.addr = ($urandom_range(0, 1) != 0) ? 32'h0000_FFFC + 32'($urandom_range(0, 2) * 4)
                                                       : 32'h1100_0FFC + 32'($urandom_range(0, 2) * 4);
      endcase
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.d     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      v.stray = $urandom_range(0, 4);
      model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a RAM access that never acks.
    busRead = 1'b1; busWrite = 1'b0; bus_addr = 32'h0000_0080; bus_in = 32'h0;
    @(posedge clk); #1;
    busRead = 1'b0;
    chk("rst_pre sel", {31'b0, ram_sel}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid outs", {bus_ready, error, ram_sel, mmio_sel, slv_we}, 32'h0);
    chk("rst_mid addr", slv_addr, 32'h0);
    chk("rst_mid bus_out", bus_out, 32'h0);
    $display("txn rst_mid   ram_sel=%0b bus_ready=%0b", ram_sel, bus_ready);
    @(posedge clk); #1;
    chk("rst_hold ready", {31'b0, bus_ready}, 32'h0);
    rst = 1'b0;
    model_out = 32'h0;
    v = '{1'b1,1'b0,32'h0000_0084,32'h0,0,32'h7777_1234,0,2,1'b0,2'b01,1,32'h7777_1234};
    run_txn(v, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Bus controller sitting directly downstream of the CPU's unified instruction/data bus. It accepts single-word read/write requests, decodes the address to one of two slaves (RAM, MMIO), and runs a request/acknowledge handshake with the selected slave. It returns read data, a completion strobe, and an error pulse to the CPU. The error pulse is driven into the control unit's `error` input on unmapped, misaligned, conflicting or timed-out accesses.

## Interface
- RAM_BASE, 32'h0000_0000, RAM window base (aligned to window size)
- RAM_AW, 16, log2 of RAM window size in bytes
- MMIO_BASE, 32'h1100_0000, MMIO window base (aligned to window size)
- MMIO_AW, 12, log2 of MMIO window size in bytes
- TIMEOUT_CYCLES, 16, maximum cycles a slave select is held without ack (≥2)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- busRead / busWrite  in  1 each  CPU read / write request, level
- bus_addr  in  32  CPU byte address
- bus_in  in  32  CPU write data
- bus_out  out  32  read data to CPU, registered
- bus_ready  out  1  one-cycle completion strobe (also on fault)
- error  out  1  one-cycle fault strobe, coincident with bus_ready
- ram_sel, mmio_sel  out  1 each  slave select, held until ack or timeout
- slv_we  out  1  write enable to selected slave
- slv_addr  out  32  latched address (shared by both slaves)
- slv_wdata  out  32  latched write data (shared by both slaves)
- ram_rdata, mmio_rdata  in  32 each  slave read data, valid with ack
- ram_ack, mmio_ack  in  1 each  slave acknowledge

## Operation
- FSM states: IDLE, ACCESS, DONE, FAULT.
- IDLE, no request: stay in IDLE.
- IDLE, request present: latch addr, wdata and we (we=busWrite) into the slv_* registers, then classify:
  - busRead and busWrite both high → FAULT.
  - bus_addr[1:0]≠0 → FAULT.
  - No window hit → FAULT.
  - Otherwise latch the target and go to ACCESS.
- Window hit: (bus_addr >> AW) == (BASE >> AW). RAM is checked first if windows overlap.
- ACCESS:
  - Target's sel=1.
  - Target's ack=1 → capture the target's rdata into bus_out on reads (bus_out unchanged on writes), go to DONE.
  - The non-target slave's ack is ignored.
- DONE: bus_ready=1 → IDLE.
- FAULT: bus_ready=1, error=1, bus_out←0 → IDLE. No slave is selected on a fault.
- The requester must deassert on the cycle after bus_ready. A request still high in IDLE is treated as a new request.

## Timing
- Reset values:
  - state=IDLE.
  - bus_out=0, bus_ready=0, error=0.
  - ram_sel=mmio_sel=0, slv_we=0, slv_addr=0, slv_wdata=0.
  - Timeout counter=0.
- Reset is asynchronous and applies mid-access: sel drops immediately and the transaction is abandoned with no bus_ready.
- Outputs are registered from state and latched values. There are no combinational paths from CPU inputs to outputs.
- Cycle numbering for a mapped access, request sampled at edge 0:
  - sel high in cycle 1.
  - Ack sampled at edge n (n≥1) → bus_ready in cycle n+1.
  - Minimum latency: request edge to bus_ready = 2 cycles.
- Fault latency: bus_ready/error in cycle 1.
- Timeout counter: width clog2(TIMEOUT_CYCLES). Cleared on IDLE→ACCESS, increments each ACCESS cycle without ack. If the count reaches TIMEOUT_CYCLES−1 without ack → FAULT, so sel is high for exactly TIMEOUT_CYCLES cycles.
- Ack on the final allowed cycle wins over timeout (→ DONE).

## Configuration
- BUS_CTRL_TIMEOUT_EN defined: watchdog counter present, behaviour as above.
- Undefined: no counter, ACCESS waits indefinitely for ack, and FAULT is reached only from IDLE classification. TIMEOUT_CYCLES is ignored.

## Structure
- Shared package bus_pkg:
  - typedef enum bus_state_t {IDLE, ACCESS, DONE, FAULT}.
  - typedef enum bus_tgt_t {TGT_RAM, TGT_MMIO}.
  - Default window base/size constants, used as the parameter defaults.
- One sub-module, bus_decode: combinational address/alignment/conflict classifier returning {hit, tgt_t, fault}. The FSM, latches and counter stay in bus_ctrl.

## Test plan
- RAM read: busRead, addr 0x0000_0040, ram_ack on first sel cycle with rdata 0xDEADBEEF → ram_sel for 1 cycle, bus_out=0xDEADBEEF, bus_ready 2 cycles after request, error=0.
- MMIO write with 3-cycle ack delay: busWrite, addr 0x1100_0004, wdata 0x0000_00A5 → mmio_sel=1, slv_we=1, slv_wdata=0xA5 for 3 cycles, bus_ready after, bus_out unchanged.
- Faults, each expecting bus_ready=error=1 in cycle 1, no sel, bus_out=0:
  - unmapped read at 0x2000_0000
  - misaligned read at 0x0000_0002
  - busRead and busWrite both high
- Timeout, TIMEOUT_CYCLES=16, ram never acks → ram_sel high exactly 16 cycles, then error+bus_ready. Ack on the 16th cycle → normal DONE, no error.
- Stray ack: mmio_ack pulsed during a RAM access → ignored, completion only on ram_ack.
- Reset mid-ACCESS: rst asserted while ram_sel=1 → ram_sel and all outputs 0 asynchronously, no bus_ready. A new request after reset release completes normally.
